// File: rtl/div_iter_ctrl.sv
// div_iter_ctrl
//   Multi-cycle integer divider for the EX stage. It accepts one signed or
//   unsigned div/mod request, runs a radix-2 restoring division on operand
//   magnitudes (one quotient bit per cycle, MSB first), applies the result
//   signs and returns quotient and remainder together.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   flush              cancels any in-flight operation (ertn / exception)
//   req_valid/ready    request handshake; ready = IDLE & ~flush
//   req_signed         1 = div.w/mod.w, 0 = div.wu/mod.wu
//   req_src1/src2      dividend / divisor, sampled at the handshake edge only
//   resp_valid/ready   response handshake; result held while not taken
//   resp_quot/rem      quotient / remainder (remainder sign follows dividend)
//   busy               controller is not idle
//
// state | meaning
// IDLE  | waiting for a request
// CALC  | one restoring-division step per cycle, DATA_W steps
// FIX   | apply quotient/remainder signs, register the result
// DONE  | result presented until resp_ready or flush
module div_iter_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_signed,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_quot,
  output logic [DATA_W-1:0] resp_rem,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic              sign_q;
  logic              sign_r;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] rem_q;
  // Holds the dividend magnitude at start; dividend bits shift out of the
  // top while quotient bits shift in at the bottom, so it ends as the quotient.
  logic [DATA_W-1:0] dq_q;
  logic [CNT_W-1:0]  iter_q;

  logic [DATA_W-1:0] src1_abs;
  logic [DATA_W-1:0] src2_abs;
  logic [DATA_W:0]   trial;
  logic              trial_ge;
  logic [DATA_W-1:0] rem_next;

  assign req_ready = (state == IDLE) & ~flush;
  assign busy      = (state != IDLE);

  always_comb begin
    src1_abs = (req_signed & req_src1[DATA_W-1]) ? -req_src1 : req_src1;
    src2_abs = (req_signed & req_src2[DATA_W-1]) ? -req_src2 : req_src2;
    // Trial kept one bit wider than the operands: with unsigned divisors
    // above 2^(DATA_W-1) the shifted remainder can exceed DATA_W bits.
    trial    = {rem_q, dq_q[DATA_W-1]};
    trial_ge = (trial >= {1'b0, divisor_q});
    // The difference is always below the divisor, so the low DATA_W bits
    // of the subtraction are exact.
    rem_next = trial_ge ? (trial[DATA_W-1:0] - divisor_q) : trial[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_quot  <= '0;
      resp_rem   <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      divisor_q  <= '0;
      rem_q      <= '0;
      dq_q       <= '0;
      iter_q     <= '0;
    end else if (flush && (state != IDLE)) begin
      // Results are discarded; resp_quot/resp_rem keep their last value.
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            sign_q    <= req_signed & (req_src1[DATA_W-1] ^ req_src2[DATA_W-1]);
            sign_r    <= req_signed & req_src1[DATA_W-1];
            dq_q      <= src1_abs;
            divisor_q <= src2_abs;
            rem_q     <= '0;
            iter_q    <= '0;
            if (req_src2 == '0) begin
              resp_quot  <= '1;
              resp_rem   <= req_src1;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_next;
          dq_q   <= {dq_q[DATA_W-2:0], trial_ge};
          iter_q <= iter_q + CNT_W'(1);
          if (iter_q == CNT_W'(DATA_W - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          resp_quot  <= sign_q ? -dq_q : dq_q;
          resp_rem   <= sign_r ? -rem_q : rem_q;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
